debounce_scheduler: RTL and testbench
=====================================

# debounce_scheduler

Multi-channel switch debouncer in which one shared sample-rate prescaler and one sequential scanner serve `N_CH` raw switch inputs. Each channel gets a synchronizer and a small stability counter. The scanner visits the channels round-robin, one per clock, on every sample strobe. Qualified level changes are published as per-channel level and tick outputs, and as a single-slot valid/ready event stream for a downstream consumer such as a UART logger or menu FSM. It replaces per-button 26-bit counters on boards with many buttons.

## Interface
- `N_CH`, default 4: number of switch channels, at least 2.
- `CLK_DIV`, default 500_000: clocks per sample strobe. Must be ≥ `N_CH` + 2.
- `STABLE_CNT`, default 8: consecutive differing samples required to flip a level, range 1..255.
- `clk_i` input, 1 bit: clock.
- `rst_i` input, 1 bit: reset, asynchronous, active-high.
- `sw_i` input, `N_CH` bits: raw, asynchronous switch levels.
- `db_level_o` output, `N_CH` bits: debounced levels.
- `db_tick_o` output, `N_CH` bits: one-cycle pulse on each debounced rising edge.
- `evt_valid_o` output, 1 bit: event slot holds an event.
- `evt_ready_i` input, 1 bit: consumer accepts the event.
- `evt_ch_o` output, `$clog2(N_CH)` bits: channel index of the event.
- `evt_level_o` output, 1 bit: new debounced level of that channel.
- `busy_o` output, 1 bit: FSM is not in IDLE.
- `overrun_o` output, 1 bit: sticky flag, set when a strobe arrives while one is already pending.

## Operation
**Synchronizer**
- 2-FF synchronizer per channel.
- Reset value 0.

**Prescaler**
- Free-running, counts 0..`CLK_DIV`-1 and wraps.
- `strobe` is asserted for one cycle when the count equals `CLK_DIV`-1.

**Per-channel state**
- `level[ch]`: 1 bit, drives `db_level_o`.
- `cnt[ch]`: 8 bits, saturating arithmetic.

**FSM states: IDLE, SCAN, WAIT**
- IDLE: on `strobe`, go to SCAN with `idx`=0.
- SCAN: visit channel `idx` in this cycle.
  - If `sync[idx]` == `level[idx]`: set `cnt[idx]`=0.
  - Else, if `cnt[idx]+1` < `STABLE_CNT`: increment `cnt[idx]`.
  - Else the channel qualifies. It commits only if the slot is free, i.e. `!evt_valid_o || evt_ready_i`. On commit:
    - `level[idx]` toggles and `cnt[idx]`=0.
    - The slot loads {`idx`, new level}.
    - On a rising change, `db_tick_o[idx]` pulses in the next cycle.
  - If the channel qualifies but the slot is not free: go to WAIT with no state change and `idx` held.
  - After a non-stalled visit with `idx` == `N_CH`-1:
    - If `pending`, clear it and go to SCAN with `idx`=0.
    - Otherwise go to IDLE.
  - Otherwise increment `idx`.
- WAIT: when the slot is free, return to SCAN with the same `idx`. The channel is then re-evaluated using the current `sync` value. If the input bounced back, no event is produced.

**Pending and overrun**
- A `strobe` in SCAN or WAIT sets `pending`.
- A `strobe` while `pending` is already 1 sets `overrun_o`. It stays set until reset.

**Event slot**
- `evt_valid_o && evt_ready_i` clears the slot.
- If a load happens in the same cycle as acceptance, the load wins: valid stays 1 and the new data is presented.
- Data is stable while valid is high and not accepted.

**Outputs**
- `busy_o` = (state != IDLE).

## Timing
**Reset**
- All outputs are 0, including `db_level_o`, `db_tick_o`, `evt_*`, `busy_o` and `overrun_o`.
- FSM is IDLE, prescaler is 0, `idx`=0, `pending`=0, all `cnt`=0.
- Reset asserted mid-scan or during WAIT aborts immediately. A pending event is discarded.

**Latencies**
- `sw_i` to `sync`: 2 cycles.
- Strobe to SCAN of channel k: k+1 cycles.
- A committed change appears on `db_level_o`, `evt_valid_o`, `evt_ch_o` and `evt_level_o` in the cycle after the SCAN visit.
- `db_tick_o` appears 1 cycle after the `db_level_o` rise and is exactly 1 cycle wide.

**Scan duration and detection time**
- An unstalled scan takes `N_CH` cycles.
- Detection time after the input settles is between (`STABLE_CNT`-1)·`CLK_DIV` and `STABLE_CNT`·`CLK_DIV` + `N_CH` + 3 cycles.

**Boundaries**
- `STABLE_CNT`=1: the first differing sample commits.
- Several channels may change in the same scan. Events are produced in ascending channel order, one per accepted slot.
- `evt_ready_i` tied high: never stalls, and a new event can be presented every cycle.

## Test plan
Bench parameters for all scenarios: `N_CH`=4, `CLK_DIV`=16, `STABLE_CNT`=4.

1. **Reset:** Assert `rst_i` mid-scan with `sw_i`=4'b1111 -> all outputs are 0 and `busy_o`=0 in the same cycle. After release, `db_level_o` becomes 4'b1111 only after 3–4 strobes.
2. **Bounce rejection:** Toggle `sw_i[2]` every 20 clocks for 200 clocks, then hold it at 1 -> no event during the bounce. Exactly one event follows, `evt_ch_o`=2 and `evt_level_o`=1, with `db_tick_o[2]` high for one cycle.
3. **Simultaneous changes:** Raise all 4 bits together with `evt_ready_i`=1 -> 4 events on consecutive cycles with channels 0, 1, 2, 3 in order, and 4 single-cycle ticks.
4. **Backpressure:** Hold `evt_ready_i`=0 and raise ch0 and ch1 -> ch0 event held stable, FSM in WAIT at `idx`=1, `db_level_o[1]`=0. Release `evt_ready_i` -> ch1 committed and presented in the cycle after acceptance.
5. **Overrun:** Keep `evt_ready_i`=0 with a qualifying change stalled for more than 32 clocks -> `overrun_o`=1 and it remains 1 after the stall resolves.
6. **Falling edge:** Release ch3 from 1 to 0 -> event with `evt_level_o`=0, `db_level_o[3]`=0, and no `db_tick_o` pulse.

Source files
------------

// File: rtl/debounce_scheduler.sv
// debounce_scheduler
//   Multi-channel switch debouncer. One free-running prescaler produces a
//   sample strobe every CLK_DIV clocks. On each strobe a scanner walks the
//   channels round-robin, one per clock, and updates a small per-channel
//   stability counter. A channel flips its debounced level once STABLE_CNT
//   consecutive samples disagree with it. Each flip is published through a
//   single-slot valid/ready event stream.
//
//   Ports
//     clk_i        clock
//     rst_i        asynchronous, active-high reset
//     sw_i         raw switch levels (asynchronous)
//     db_level_o   debounced levels
//     db_tick_o    one-cycle pulse, one cycle after a debounced rising edge
//     evt_valid_o  event slot holds an event
//     evt_ready_i  consumer accepts the event
//     evt_ch_o     channel index of the event
//     evt_level_o  new debounced level of that channel
//     busy_o       scanner is not idle
//     overrun_o    sticky: a strobe arrived while another was already pending
//     dbg_state_o  scanner state: 0 = IDLE, 1 = SCAN, 2 = WAIT
//     dbg_idx_o    channel index the scanner is on
//
//   Handshake: an event transfers on every clock where evt_valid_o and
//   evt_ready_i are both high. While evt_valid_o is high and not accepted,
//   evt_ch_o and evt_level_o hold still. A new event loaded in the same cycle
//   as an acceptance replaces the old one, so valid stays high.
module debounce_scheduler #(
    parameter int N_CH       = 4,
    parameter int CLK_DIV    = 500_000,
    parameter int STABLE_CNT = 8,
    localparam int IW        = $clog2(N_CH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] sw_i,
    output logic [N_CH-1:0] db_level_o,
    output logic [N_CH-1:0] db_tick_o,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic [IW-1:0]   evt_ch_o,
    output logic            evt_level_o,
    output logic            busy_o,
    output logic            overrun_o,
    output logic [1:0]      dbg_state_o,
    output logic [IW-1:0]   dbg_idx_o
);

    localparam int PW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Synchronizers
    logic [N_CH-1:0] sync1_q, sync2_q;

    // Prescaler
    logic [PW-1:0] presc_q;
    logic          strobe;

    // Scanner
    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            pending_q, pending_d;
    logic            overrun_q, overrun_d;

    // Per-channel debounce state
    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] level_dly_q;
    logic [N_CH-1:0] tick_q;
    logic [7:0]      cnt_q [N_CH];
    logic [7:0]      cnt_d [N_CH];

    // Event slot
    logic            evt_valid_q;
    logic [IW-1:0]   evt_ch_q;
    logic            evt_level_q;

    // Visit results
    logic            slot_free;
    logic            load;
    logic            load_level;
    logic            visit_done;
    logic [8:0]      cnt_inc;

    assign strobe    = (presc_q == PW'(CLK_DIV - 1));
    assign slot_free = !evt_valid_q || evt_ready_i;
    assign cnt_inc   = {1'b0, cnt_q[idx_q]} + 9'd1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        level_d    = level_q;
        cnt_d      = cnt_q;
        load       = 1'b0;
        load_level = 1'b0;
        visit_done = 1'b0;

        if (strobe && pending_q) begin
            overrun_d = 1'b1;
        end
        if (strobe && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end
            end

            ST_SCAN: begin
                if (sync2_q[idx_q] == level_q[idx_q]) begin
                    cnt_d[idx_q] = 8'd0;
                    visit_done   = 1'b1;
                end else if (cnt_inc < 9'(STABLE_CNT)) begin
                    // cnt never exceeds STABLE_CNT-1, so this cannot wrap
                    cnt_d[idx_q] = cnt_inc[7:0];
                    visit_done   = 1'b1;
                end else if (slot_free) begin
                    level_d[idx_q] = ~level_q[idx_q];
                    cnt_d[idx_q]   = 8'd0;
                    load           = 1'b1;
                    load_level     = ~level_q[idx_q];
                    visit_done     = 1'b1;
                end else begin
                    // Qualified but the slot is occupied: freeze on this channel
                    state_d = ST_WAIT;
                end

                if (visit_done) begin
                    if (idx_q == IW'(N_CH - 1)) begin
                        // A strobe landing on the last visit counts as pending
                        // so it is not lost when the scan was stretched by stalls.
                        if (pending_q || strobe) begin
                            pending_d = 1'b0;
                            state_d   = ST_SCAN;
                            idx_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end

            ST_WAIT: begin
                // Channel is re-evaluated from scratch on return to SCAN
                if (slot_free) begin
                    state_d = ST_SCAN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            presc_q     <= '0;
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            level_q     <= '0;
            level_dly_q <= '0;
            tick_q      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= 8'd0;
            end
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_level_q <= 1'b0;
        end else begin
            sync1_q     <= sw_i;
            sync2_q     <= sync1_q;
            presc_q     <= strobe ? '0 : presc_q + PW'(1);
            state_q     <= state_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            // Tick trails the level rise by one cycle
            level_dly_q <= level_q;
            tick_q      <= level_q & ~level_dly_q;
            if (load) begin
                evt_valid_q <= 1'b1;
                evt_ch_q    <= idx_q;
                evt_level_q <= load_level;
            end else if (evt_valid_q && evt_ready_i) begin
                evt_valid_q <= 1'b0;
            end
        end
    end

    assign db_level_o  = level_q;
    assign db_tick_o   = tick_q;
    assign evt_valid_o = evt_valid_q;
    assign evt_ch_o    = evt_ch_q;
    assign evt_level_o = evt_level_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign overrun_o   = overrun_q;
    assign dbg_state_o = state_q;
    assign dbg_idx_o   = idx_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Testbench for debounce_scheduler (N_CH=4, CLK_DIV=16, STABLE_CNT=4).
// A cycle-level reference model written from the behavioural rules runs
// alongside the DUT and is compared every clock; directed sequences and a
// vector table add targeted checks on top.
module tb_debounce_scheduler;

    localparam int N_CH       = 4;
    localparam int CLK_DIV    = 16;
    localparam int STABLE_CNT = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [3:0] sw_i = 4'b0000;
    logic [3:0] db_level_o;
    logic [3:0] db_tick_o;
    logic       evt_valid_o;
    logic       evt_ready_i = 1'b1;
    logic [1:0] evt_ch_o;
    logic       evt_level_o;
    logic       busy_o;
    logic       overrun_o;
    logic [1:0] dbg_state_o;
    logic [1:0] dbg_idx_o;

    int checks = 0;
    int failures = 0;
    int strobes = 0;
    int cyc = 0;

    debounce_scheduler #(
        .N_CH(N_CH),
        .CLK_DIV(CLK_DIV),
        .STABLE_CNT(STABLE_CNT)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .sw_i(sw_i),
        .db_level_o(db_level_o),
        .db_tick_o(db_tick_o),
        .evt_valid_o(evt_valid_o),
        .evt_ready_i(evt_ready_i),
        .evt_ch_o(evt_ch_o),
        .evt_level_o(evt_level_o),
        .busy_o(busy_o),
        .overrun_o(overrun_o),
        .dbg_state_o(dbg_state_o),
        .dbg_idx_o(dbg_idx_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 scanning, 2 waiting for the slot
    logic [3:0] m_s1, m_s2, m_lvl, m_lvl_d, m_tick;
    int         m_presc, m_mode, m_idx;
    int         m_cnt [N_CH];
    logic       m_pend, m_ovr, m_valid, m_elvl;
    logic [1:0] m_ch;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_d = '0; m_tick = '0;
        m_presc = 0; m_mode = 0; m_idx = 0;
        for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
        m_pend = 0; m_ovr = 0; m_valid = 0; m_elvl = 0; m_ch = '0;
    endtask

    task automatic model_update(input logic [3:0] sw, input logic rdy);
        logic strobe, free, done, old_pend;
        strobe   = (m_presc == CLK_DIV - 1);
        free     = !m_valid || rdy;
        old_pend = m_pend;
        done     = 1'b0;
        if (strobe) strobes++;
        m_tick  = m_lvl & ~m_lvl_d;
        m_lvl_d = m_lvl;
        if (strobe && old_pend) m_ovr = 1'b1;
        if (strobe && m_mode != 0) m_pend = 1'b1;
        if (m_valid && rdy) m_valid = 1'b0;
        case (m_mode)
            0: if (strobe) begin m_mode = 1; m_idx = 0; end
            1: begin
                if (m_s2[m_idx] == m_lvl[m_idx]) begin
                    m_cnt[m_idx] = 0; done = 1'b1;
                end else if (m_cnt[m_idx] + 1 < STABLE_CNT) begin
                    m_cnt[m_idx]++; done = 1'b1;
                end else if (free) begin
                    m_lvl[m_idx] = ~m_lvl[m_idx];
                    m_cnt[m_idx] = 0;
                    m_valid = 1'b1;
                    m_ch = 2'(m_idx);
                    m_elvl = m_lvl[m_idx];
                    done = 1'b1;
                end else begin
                    m_mode = 2;
                end
                if (done) begin
                    if (m_idx == N_CH - 1) begin
                        if (old_pend || strobe) begin m_pend = 1'b0; m_idx = 0; end
                        else m_mode = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end
            default: if (free) m_mode = 1;
        endcase
        m_s2 = m_s1;
        m_s1 = sw;
        m_presc = (m_presc + 1) % CLK_DIV;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: advance the model with the inputs the DUT sees at this edge,
    // then compare all outputs shortly after the edge.
    task automatic step();
        if (rst_i) model_reset();
        else model_update(sw_i, evt_ready_i);
        @(posedge clk_i);
        #1;
        cyc++;
        check("model", {18'd0, db_level_o, db_tick_o, evt_valid_o, evt_ch_o, evt_level_o, busy_o, overrun_o},
              {18'd0, m_lvl, m_tick, m_valid, m_ch, m_elvl, (m_mode != 0), m_ovr});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        strobes = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] sw;
        logic [3:0] exp_level;
        int         exp_events;
        int         exp_ticks;
    } vec_t;

    vec_t vecs [5];
    logic [2:0] exp_q [$];

    initial begin
        int n_ev, n_tk, first_cyc, idx, t_wait;
        int tk_ch [4];
        logic [1:0] last_ch;
        logic last_lvl;
        logic [2:0] exp_e;
        bit found;

        vecs[0] = '{4'b0001, 4'b0001, 1, 1};
        vecs[1] = '{4'b1111, 4'b1111, 3, 3};
        vecs[2] = '{4'b0101, 4'b0101, 2, 0};
        vecs[3] = '{4'b1010, 4'b1010, 4, 2};
        vecs[4] = '{4'b0000, 4'b0000, 2, 0};

        model_reset();
        #2;
        check("reset_outputs", {db_level_o, db_tick_o, evt_valid_o, evt_ch_o, evt_level_o, busy_o, overrun_o}, 0);
        do_reset();

        // ---- 1. reset mid-scan ----
        sw_i = 4'b1111;
        evt_ready_i = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (busy_o) found = 1;
        end
        check("reach_busy", found, 1);
        #3 rst_i = 1'b1;
        #1;
        check("async_reset_outputs", {db_level_o, db_tick_o, evt_valid_o, evt_ch_o, evt_level_o, busy_o, overrun_o}, 0);
        step();
        step();
        rst_i = 1'b0;
        strobes = 0;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (db_level_o == 4'b1111) found = 1;
        end
        check("relevel_after_reset", found, 1);
        check("relevel_strobes_3_to_4", (strobes >= 3 && strobes <= 4), 1);

        // ---- 2. bounce rejection ----
        sw_i = 4'b0000;
        do_reset();
        run(20);
        n_ev = 0;
        for (int k = 0; k < 10; k++) begin
            sw_i[2] = ~sw_i[2];
            for (int i = 0; i < 20; i++) begin
                step();
                if (evt_valid_o && evt_ready_i) n_ev++;
            end
        end
        check("bounce_no_event", n_ev, 0);
        sw_i[2] = 1'b1;
        n_ev = 0; n_tk = 0; last_ch = '0; last_lvl = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (evt_valid_o && evt_ready_i) begin
                n_ev++; last_ch = evt_ch_o; last_lvl = evt_level_o;
            end
            if (db_tick_o[2]) n_tk++;
        end
        check("bounce_event_count", n_ev, 1);
        check("bounce_event_ch", last_ch, 2);
        check("bounce_event_level", last_lvl, 1);
        check("bounce_tick_cycles", n_tk, 1);
        check("bounce_level", db_level_o, 4'b0100);

        // ---- 3. simultaneous changes ----
        sw_i = 4'b0000;
        do_reset();
        run(20);
        for (int c = 0; c < 4; c++) begin
            exp_q.push_back({2'(c), 1'b1});
            tk_ch[c] = 0;
        end
        sw_i = 4'b1111;
        idx = 0; first_cyc = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            for (int c = 0; c < 4; c++) if (db_tick_o[c]) tk_ch[c]++;
            if (evt_valid_o && evt_ready_i) begin
                if (idx == 0) first_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("sim_extra_event", 1, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("sim_event", {evt_ch_o, evt_level_o}, exp_e);
                    check("sim_event_consecutive", cyc - first_cyc, idx);
                end
                idx++;
            end
        end
        check("sim_all_events_seen", exp_q.size(), 0);
        for (int c = 0; c < 4; c++) check("sim_tick_cycles", tk_ch[c], 1);

        // ---- 4. backpressure ----
        sw_i = 4'b0000;
        evt_ready_i = 1'b0;
        do_reset();
        run(20);
        sw_i = 4'b0011;
        found = 0;
        for (int i = 0; i < 150 && !found; i++) begin
            step();
            if (dbg_state_o == 2'd2) found = 1;
        end
        check("bp_reach_wait", found, 1);
        check("bp_slot_ch0", {evt_valid_o, evt_ch_o, evt_level_o}, {1'b1, 2'd0, 1'b1});
        check("bp_wait_idx", dbg_idx_o, 1);
        check("bp_level1_low", db_level_o[1], 0);
        run(5);
        check("bp_slot_stable", {evt_valid_o, evt_ch_o, evt_level_o}, {1'b1, 2'd0, 1'b1});
        evt_ready_i = 1'b1;
        step();
        found = 0; t_wait = 0;
        for (int i = 0; i < 2 && !found; i++) begin
            step();
            t_wait++;
            if (evt_valid_o && evt_ch_o == 2'd1) found = 1;
        end
        check("bp_ch1_presented", found, 1);
        check("bp_ch1_level", {evt_level_o, db_level_o[1]}, 2'b11);
        run(20);

        // ---- 5. overrun ----
        sw_i = 4'b0000;
        evt_ready_i = 1'b0;
        do_reset();
        run(20);
        sw_i = 4'b0011;
        found = 0;
        for (int i = 0; i < 150 && !found; i++) begin
            step();
            if (dbg_state_o == 2'd2) found = 1;
        end
        check("ovr_reach_wait", found, 1);
        check("ovr_clear_before", overrun_o, 0);
        run(40);
        check("ovr_set", overrun_o, 1);
        evt_ready_i = 1'b1;
        run(100);
        check("ovr_sticky", overrun_o, 1);
        check("ovr_resolved_level", db_level_o, 4'b0011);

        // ---- 6. falling edge ----
        sw_i = 4'b1000;
        evt_ready_i = 1'b1;
        do_reset();
        run(120);
        check("fall_setup_level", db_level_o, 4'b1000);
        sw_i = 4'b0000;
        n_ev = 0; n_tk = 0; last_ch = '0; last_lvl = 1;
        for (int i = 0; i < 120; i++) begin
            step();
            if (evt_valid_o && evt_ready_i) begin
                n_ev++; last_ch = evt_ch_o; last_lvl = evt_level_o;
            end
            if (db_tick_o != 4'b0000) n_tk++;
        end
        check("fall_event_count", n_ev, 1);
        check("fall_event", {last_ch, last_lvl}, {2'd3, 1'b0});
        check("fall_level", db_level_o, 4'b0000);
        check("fall_no_tick", n_tk, 0);

        // ---- table vectors ----
        sw_i = 4'b0000;
        evt_ready_i = 1'b1;
        do_reset();
        run(20);
        for (int v = 0; v < 5; v++) begin
            sw_i = vecs[v].sw;
            n_ev = 0; n_tk = 0;
            for (int i = 0; i < 110; i++) begin
                step();
                if (evt_valid_o && evt_ready_i) n_ev++;
                n_tk += $countones(db_tick_o);
            end
            check("vec_level", db_level_o, vecs[v].exp_level);
            check("vec_events", n_ev, vecs[v].exp_events);
            check("vec_ticks", n_tk, vecs[v].exp_ticks);
        end

        // ---- randomized run against the model ----
        do_reset();
        for (int blk = 0; blk < 40; blk++) begin
            int rmode;
            rmode = $urandom_range(0, 2);
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 11) == 0) sw_i[$urandom_range(0, 3)] = ~sw_i[$urandom_range(0, 3)];
                case (rmode)
                    0: evt_ready_i = 1'b1;
                    1: evt_ready_i = ($urandom_range(0, 1) == 1);
                    default: evt_ready_i = ($urandom_range(0, 7) == 0);
                endcase
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
